if_fetch_buffer: RTL and testbench

- Parametrised fetch buffer between the icache response stage and decode. Successor to the single-entry IF1 staging register.
- Tracks up to MAX_INFLIGHT outstanding icache fetches, reserves buffer space before issuing a fetch, and aligns each FETCH_W-wide fetch block by PC.
- Queues instructions in a circular buffer and presents up to ISSUE_W instructions per cycle to decode.
- Responses still in flight when a flush arrives are discarded by a stale-response counter, not by a full pipeline drain.

---
 rtl/if_fetch_buffer_if.sv | 44 ++++
 rtl/if_fetch_buffer.sv | 142 ++++++++++++++
 tb/tb_if_fetch_buffer.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_buffer_if.sv
// Fetch-buffer bus: IF0 request, icache response and the decode issue window.
interface if_fetch_buffer_if #(
  parameter int FETCH_W      = 2,
  parameter int ISSUE_W      = 2,
  parameter int DEPTH        = 8,
  parameter int MAX_INFLIGHT = 2
);
  logic                              flush;
  logic                              req_valid;
  logic [31:0]                       req_pc;
  logic                              req_ready;
  logic                              resp_valid;
  logic [FETCH_W*32-1:0]             resp_inst;
  logic                              resp_taken;
  logic [31:0]                       resp_pc_next;
  logic                              resp_excp;
  logic [6:0]                        resp_ecode;
  logic [31:0]                       resp_badv;
  logic [ISSUE_W-1:0]                out_valid;
  logic [ISSUE_W*32-1:0]             out_inst;
  logic [ISSUE_W*32-1:0]             out_pc;
  logic [ISSUE_W-1:0]                out_taken;
  logic [ISSUE_W*32-1:0]             out_pc_next;
  logic [ISSUE_W-1:0]                out_excp;
  logic [ISSUE_W*7-1:0]              out_ecode;
  logic [ISSUE_W*32-1:0]             out_badv;
  logic                              out_ready;
  logic [$clog2(DEPTH):0]            count;
  logic [$clog2(MAX_INFLIGHT):0]     inflight;
  logic                              proto_err;

  modport master (
    output flush, req_valid, req_pc, resp_valid, resp_inst, resp_taken, resp_pc_next,
           resp_excp, resp_ecode, resp_badv, out_ready,
    input  req_ready, out_valid, out_inst, out_pc, out_taken, out_pc_next, out_excp,
           out_ecode, out_badv, count, inflight, proto_err
  );
  modport slave (
    input  flush, req_valid, req_pc, resp_valid, resp_inst, resp_taken, resp_pc_next,
           resp_excp, resp_ecode, resp_badv, out_ready,
    output req_ready, out_valid, out_inst, out_pc, out_taken, out_pc_next, out_excp,
           out_ecode, out_badv, count, inflight, proto_err
  );
endinterface

// File: rtl/if_fetch_buffer.sv
// Fetch buffer: reserves space per outstanding icache fetch, aligns blocks by PC,
// queues instructions and presents up to ISSUE_W of them to decode.
module if_fetch_buffer #(
  parameter int          FETCH_W      = 2,
  parameter int          ISSUE_W      = 2,
  parameter int          DEPTH        = 8,
  parameter int          MAX_INFLIGHT = 2,
  parameter logic [31:0] NOP          = 32'h0340_0000
) (
  input logic          clk,
  input logic          rst,
  if_fetch_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int IW = $clog2(MAX_INFLIGHT) + 1;
  localparam int QW = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] badv;
    logic        taken;
    logic        excp;
    logic [6:0]  ecode;
  } entry_t;

  entry_t        r_mem [DEPTH];
  logic [31:0]   r_pcq [MAX_INFLIGHT];
  logic [AW-1:0] r_head, r_tail;
  logic [CW-1:0] r_count;
  logic [IW-1:0] r_inflight, r_stale;
  logic [QW-1:0] r_qhead, r_qtail;
  logic          r_proto_err;

  logic               w_accept, w_resp, w_keep;
  logic [31:0]        w_pc;
  int                 w_off;
  entry_t             w_ent [FETCH_W];
  logic [FETCH_W-1:0] w_we;
  logic [CW-1:0]      w_nwr, w_npop;

  function automatic logic [QW-1:0] qinc(input logic [QW-1:0] p);
    return (int'(p) == MAX_INFLIGHT - 1) ? '0 : p + 1'b1;
  endfunction

  // Reserve a whole block per outstanding fetch so a response always fits.
  assign bus.req_ready = !rst && !bus.flush && (int'(r_inflight) < MAX_INFLIGHT) &&
                         (int'(r_count) + (int'(r_inflight) + 1) * FETCH_W <= DEPTH);
  assign w_accept = bus.req_valid && bus.req_ready;
  assign w_resp   = bus.resp_valid && (r_inflight != '0);
  assign w_keep   = w_resp && !bus.flush && (r_stale == '0);
  assign w_pc     = r_pcq[r_qhead];

  always_comb begin
    w_off = int'((w_pc >> 2) & 32'(FETCH_W - 1));
    w_we  = '0;
    for (int i = 0; i < FETCH_W; i++) begin
      w_ent[i] = '0;
      if (bus.resp_excp) begin
        if (i == 0) begin
          w_we[i]        = 1'b1;
          w_ent[i].inst  = NOP;
          w_ent[i].pc    = w_pc;
          w_ent[i].excp  = 1'b1;
          w_ent[i].ecode = bus.resp_ecode;
          w_ent[i].badv  = bus.resp_badv;
        end
      end else if (i < FETCH_W - w_off) begin
        w_we[i]       = 1'b1;
        w_ent[i].inst = bus.resp_inst[(w_off + i)*32 +: 32];
        w_ent[i].pc   = w_pc + 32'(4 * i);
        if (bus.resp_taken && (i == FETCH_W - w_off - 1)) begin
          w_ent[i].taken   = 1'b1;
          w_ent[i].pc_next = bus.resp_pc_next;
        end
      end
    end
    w_nwr = '0;
    if (w_keep) w_nwr = bus.resp_excp ? CW'(1) : CW'(FETCH_W - w_off);
    w_npop = '0;
    if (bus.out_ready) w_npop = (int'(r_count) < ISSUE_W) ? r_count : CW'(ISSUE_W);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_inflight  <= '0;
      r_stale     <= '0;
      r_qhead     <= '0;
      r_qtail     <= '0;
      r_proto_err <= 1'b0;
    end else begin
      if (bus.resp_valid && (r_inflight == '0)) r_proto_err <= 1'b1;
      if (bus.flush) begin
        // Responses already in flight are counted as stale and dropped on arrival.
        r_head     <= '0;
        r_tail     <= '0;
        r_count    <= '0;
        r_qhead    <= '0;
        r_qtail    <= '0;
        r_inflight <= r_inflight - IW'(w_resp);
        r_stale    <= r_inflight - IW'(w_resp);
      end else begin
        r_inflight <= r_inflight + IW'(w_accept) - IW'(w_resp);
        if (w_resp && (r_stale != '0)) r_stale <= r_stale - 1'b1;
        if (w_accept) begin
          r_pcq[r_qtail] <= bus.req_pc;
          r_qtail        <= qinc(r_qtail);
        end
        if (w_keep) r_qhead <= qinc(r_qhead);
        for (int i = 0; i < FETCH_W; i++)
          if (w_keep && w_we[i]) r_mem[r_tail + AW'(i)] <= w_ent[i];
        r_tail  <= r_tail + AW'(w_nwr);
        r_head  <= r_head + AW'(w_npop);
        r_count <= r_count + w_nwr - w_npop;
      end
    end
  end

  for (genvar k = 0; k < ISSUE_W; k++) begin : g_out
    entry_t w_e;
    logic   w_v;
    assign w_v = !rst && (int'(r_count) > k);
    assign w_e = r_mem[r_head + AW'(k)];
    assign bus.out_valid[k]              = w_v;
    assign bus.out_inst[k*32 +: 32]      = w_v ? w_e.inst    : '0;
    assign bus.out_pc[k*32 +: 32]        = w_v ? w_e.pc      : '0;
    assign bus.out_taken[k]              = w_v && w_e.taken;
    assign bus.out_pc_next[k*32 +: 32]   = w_v ? w_e.pc_next : '0;
    assign bus.out_excp[k]               = w_v && w_e.excp;
    assign bus.out_ecode[k*7 +: 7]       = w_v ? w_e.ecode   : '0;
    assign bus.out_badv[k*32 +: 32]      = w_v ? w_e.badv    : '0;
  end

  assign bus.count     = rst ? '0 : r_count;
  assign bus.inflight  = rst ? '0 : r_inflight;
  assign bus.proto_err = !rst && r_proto_err;
endmodule

// File: tb/tb_if_fetch_buffer.sv
// Randomized and directed bench for if_fetch_buffer against a queue-based model.
module tb_if_fetch_buffer;
  localparam int FW = 2, IW = 2, DEPTH = 8, MAXI = 2;
  localparam logic [31:0] NOP = 32'h0340_0000;

  logic clk, rst;
  int   n_chk, n_err;

  if_fetch_buffer_if #(.FETCH_W(FW), .ISSUE_W(IW), .DEPTH(DEPTH), .MAX_INFLIGHT(MAXI)) bus ();
  if_fetch_buffer #(.FETCH_W(FW), .ISSUE_W(IW), .DEPTH(DEPTH), .MAX_INFLIGHT(MAXI), .NOP(NOP))
    dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst, pc, pc_next, badv;
    bit          taken, excp;
    logic [6:0]  ecode;
  } ment_t;

  ment_t       ent_q [$];
  logic [31:0] pcq [$];
  int          infl, stale;
  bit          perr;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit exp_ready();
    return !rst && !bus.flush && infl < MAXI && (ent_q.size() + (infl + 1) * FW <= DEPTH);
  endfunction

  task automatic check_all();
    logic [IW-1:0] ev;
    if (rst) begin
      chk("rst_ready", 64'(bus.req_ready), 0);
      chk("rst_count", 64'(bus.count), 0);
      chk("rst_inflight", 64'(bus.inflight), 0);
      chk("rst_proto", 64'(bus.proto_err), 0);
      chk("rst_valid", 64'(bus.out_valid), 0);
      chk("rst_inst", 64'(bus.out_inst), 0);
      chk("rst_pc", 64'(bus.out_pc), 0);
      chk("rst_flags", 64'({bus.out_taken, bus.out_excp, bus.out_ecode}), 0);
      chk("rst_pcn_badv", 64'(bus.out_pc_next | bus.out_badv), 0);
    end else begin
      chk("req_ready", 64'(bus.req_ready), 64'(exp_ready()));
      chk("count", 64'(bus.count), 64'(ent_q.size()));
      chk("inflight", 64'(bus.inflight), 64'(infl));
      chk("proto_err", 64'(bus.proto_err), 64'(perr));
      chk("count_le_depth", 64'(bus.count <= DEPTH), 1);
      ev = '0;
      for (int k = 0; k < IW; k++) if (k < ent_q.size()) ev[k] = 1'b1;
      chk("out_valid", 64'(bus.out_valid), 64'(ev));
      for (int k = 0; k < IW && k < ent_q.size(); k++) begin
        chk($sformatf("inst%0d", k), 64'(bus.out_inst[k*32 +: 32]), 64'(ent_q[k].inst));
        chk($sformatf("pc%0d", k), 64'(bus.out_pc[k*32 +: 32]), 64'(ent_q[k].pc));
        chk($sformatf("taken%0d", k), 64'(bus.out_taken[k]), 64'(ent_q[k].taken));
        chk($sformatf("excp%0d", k), 64'(bus.out_excp[k]), 64'(ent_q[k].excp));
        if (ent_q[k].taken)
          chk($sformatf("pcnext%0d", k), 64'(bus.out_pc_next[k*32 +: 32]), 64'(ent_q[k].pc_next));
        if (ent_q[k].excp) begin
          chk($sformatf("ecode%0d", k), 64'(bus.out_ecode[k*7 +: 7]), 64'(ent_q[k].ecode));
          chk($sformatf("badv%0d", k), 64'(bus.out_badv[k*32 +: 32]), 64'(ent_q[k].badv));
        end
      end
    end
  endtask

  // Model of one clock edge, from the inputs currently applied.
  task automatic model_step();
    bit    rdy, rsp;
    int    npop, off;
    ment_t e;
    logic [31:0] pc;
    rdy = exp_ready();
    if (rst) begin
      ent_q.delete(); pcq.delete(); infl = 0; stale = 0; perr = 0;
      return;
    end
    if (bus.resp_valid && infl == 0) perr = 1;
    rsp = bus.resp_valid && infl > 0;
    if (bus.flush) begin
      ent_q.delete(); pcq.delete();
      if (rsp) infl--;
      stale = infl;
      return;
    end
    npop = bus.out_ready ? ((ent_q.size() < IW) ? ent_q.size() : IW) : 0;
    repeat (npop) void'(ent_q.pop_front());
    if (rsp) begin
      infl--;
      if (stale > 0) stale--;
      else begin
        pc  = pcq.pop_front();
        off = (pc / 4) % FW;
        if (bus.resp_excp) begin
          e = '{inst: NOP, pc: pc, pc_next: 0, badv: bus.resp_badv, taken: 0, excp: 1,
                ecode: bus.resp_ecode};
          ent_q.push_back(e);
        end else begin
          for (int i = 0; i < FW - off; i++) begin
            e = '{inst: bus.resp_inst[(off+i)*32 +: 32], pc: pc + 4*i, pc_next: 0, badv: 0,
                  taken: 0, excp: 0, ecode: 0};
            if (bus.resp_taken && i == FW - off - 1) begin
              e.taken = 1; e.pc_next = bus.resp_pc_next;
            end
            ent_q.push_back(e);
          end
        end
      end
    end
    if (bus.req_valid && rdy) begin
      pcq.push_back(bus.req_pc);
      infl++;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    check_all();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.flush = 0; bus.req_valid = 0; bus.req_pc = 0; bus.resp_valid = 0; bus.resp_inst = 0;
    bus.resp_taken = 0; bus.resp_pc_next = 0; bus.resp_excp = 0; bus.resp_ecode = 0;
    bus.resp_badv = 0; bus.out_ready = 0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && (ent_q.size() > 0 || infl > 0); i++) begin
      idle(); bus.out_ready = 1; bus.resp_valid = (infl > 0); bus.resp_inst = {$urandom, $urandom};
      cycle();
    end
    chk("drain_count", 64'(bus.count), 0);
    chk("drain_inflight", 64'(bus.inflight), 0);
  endtask

  initial begin
    n_chk = 0; n_err = 0;
    infl = 0; stale = 0; perr = 0;
    rst = 1; idle();
    cycle(); cycle();
    rst = 0;
    cycle();

    // Aligned block
    idle(); bus.req_valid = 1; bus.req_pc = 32'h1C00_0000; cycle();
    idle(); bus.resp_valid = 1; bus.resp_inst = {32'hB, 32'hA}; cycle();
    chk("t1_valid", 64'(bus.out_valid), 64'b11);
    chk("t1_pc", 64'(bus.out_pc), 64'h1C000004_1C000000);
    chk("t1_inst", 64'(bus.out_inst), 64'h0000000B_0000000A);
    idle(); bus.out_ready = 1; cycle();

    // Misaligned taken group
    idle(); bus.req_valid = 1; bus.req_pc = 32'h1C00_0004; cycle();
    idle(); bus.resp_valid = 1; bus.resp_inst = {32'h22, 32'h11}; bus.resp_taken = 1;
    bus.resp_pc_next = 32'h1C00_0100; cycle();
    chk("t2_valid", 64'(bus.out_valid), 64'b01);
    chk("t2_inst", 64'(bus.out_inst[31:0]), 64'h22);
    chk("t2_taken", 64'(bus.out_taken[0]), 1);
    chk("t2_pcnext", 64'(bus.out_pc_next[31:0]), 64'h1C000100);
    drain();

    // Fill with decode stalled
    for (int i = 0; i < 8; i++) begin
      idle(); bus.req_valid = 1; bus.req_pc = 32'h1C00_0010 + 8*i;
      bus.resp_valid = (infl > 0); bus.resp_inst = {$urandom, $urandom};
      cycle();
    end
    chk("t3_full", 64'(bus.count), 8);
    chk("t3_ready", 64'(bus.req_ready), 0);
    drain();

    // Flush with two fetches outstanding
    idle(); bus.req_valid = 1; bus.req_pc = 32'h1C00_0020; cycle();
    idle(); bus.req_valid = 1; bus.req_pc = 32'h1C00_0028; cycle();
    idle(); bus.flush = 1; cycle();
    chk("t4_count", 64'(bus.count), 0);
    chk("t4_inflight", 64'(bus.inflight), 2);
    idle(); bus.resp_valid = 1; bus.resp_inst = {32'hEE, 32'hFF}; cycle();
    idle(); bus.resp_valid = 1; bus.resp_inst = {32'hEE, 32'hFF};
    bus.req_valid = 1; bus.req_pc = 32'h1C00_0200; cycle();
    chk("t4_stale_dropped", 64'(bus.count), 0);
    idle(); bus.resp_valid = 1; bus.resp_inst = {32'hD, 32'hC}; cycle();
    chk("t4_new_pc", 64'(bus.out_pc), 64'h1C000204_1C000200);
    chk("t4_new_inst", 64'(bus.out_inst), 64'h0000000D_0000000C);
    drain();

    // Fetch exception
    idle(); bus.req_valid = 1; bus.req_pc = 32'h1C00_0300; cycle();
    idle(); bus.resp_valid = 1; bus.resp_excp = 1; bus.resp_ecode = 7'h03;
    bus.resp_badv = 32'h1C00_0300; bus.resp_inst = {32'h55, 32'h44}; cycle();
    chk("t5_valid", 64'(bus.out_valid), 64'b01);
    chk("t5_inst", 64'(bus.out_inst[31:0]), 64'h03400000);
    chk("t5_excp", 64'(bus.out_excp[0]), 1);
    chk("t5_badv", 64'(bus.out_badv[31:0]), 64'h1C000300);
    drain();

    // Random traffic
    for (int c = 0; c < 500; c++) begin
      idle();
      bus.flush        = ($urandom_range(0, 39) == 0);
      bus.req_valid    = 1'($urandom_range(0, 1));
      bus.req_pc       = 32'h1C00_0000 + ($urandom_range(0, 255) << 2);
      bus.resp_valid   = (infl > 0) && ($urandom_range(0, 2) != 0);
      bus.resp_inst    = {$urandom, $urandom};
      bus.resp_taken   = ($urandom_range(0, 3) == 0);
      bus.resp_pc_next = $urandom & 32'hFFFF_FFFC;
      bus.resp_excp    = ($urandom_range(0, 7) == 0);
      bus.resp_ecode   = 7'($urandom_range(0, 127));
      bus.resp_badv    = $urandom;
      bus.out_ready    = ($urandom_range(0, 2) != 0);
      cycle();
    end
    drain();

    // Protocol error is sticky
    idle(); bus.resp_valid = 1; cycle();
    chk("t6_proto", 64'(bus.proto_err), 1);
    idle(); cycle(); cycle();
    chk("t6_sticky", 64'(bus.proto_err), 1);

    // Reset mid-fetch
    idle(); bus.req_valid = 1; bus.req_pc = 32'h1C00_0400; cycle();
    idle(); rst = 1; cycle();
    chk("t7_rst_inflight", 64'(bus.inflight), 0);
    chk("t7_rst_valid", 64'(bus.out_valid), 0);
    rst = 0; cycle();
    chk("t7_inflight", 64'(bus.inflight), 0);
    chk("t7_proto", 64'(bus.proto_err), 0);
    chk("t7_count", 64'(bus.count), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
